uart_cmd_master: RTL

Byte-level command initiator driving the `uart_regs` register port from the UART side. It pops command bytes from the RX FIFO and decodes them into single-cycle `rd_req`/`wr_req` accesses. For reads, it pushes the returned register byte into the TX FIFO. It sits between the UART RX/TX FIFOs and `uart_regs`, and is the host-facing master for that block's read/write interface.

---
 rtl/uart_cmd_master.sv | 211 +++++++++++++++++++++
 1 files changed

// File: rtl/uart_cmd_master.sv
// ---------------------------------------------------------------------------
// uart_cmd_master
//
// Byte-level command initiator for the uart_regs register port. It pops
// command bytes from the RX FIFO and turns them into single-cycle register
// read or write strobes. Read results are pushed back into the TX FIFO.
//
// Command byte:  bit7 = 1 write / 0 read, bits[6:3] must be zero,
//                bits[2:0] register address.
// A write command is followed by exactly one data byte.
//
// Optional feature macro: UART_CMD_ACK_EN
//   defined   - every completed write pushes ACK_BYTE into the TX FIFO
//   undefined - writes produce no TX traffic (ACK state not built)
//
// Parameters:
//   TIMEOUT_CYCLES  max GET_DATA cycles spent waiting for a write data byte (>= 2)
//   ACK_BYTE        byte pushed after a completed write (ACK build only)
//
// Ports:
//   i_clk         clock, rising edge
//   i_rst_n       asynchronous active-low reset
//   i_rx_fifo_e   RX FIFO empty
//   i_rx_data     RX FIFO head byte (first-word-fall-through)
//   o_rx_rd       RX pop strobe
//   i_tx_fifo_f   TX FIFO full
//   o_tx_data     byte presented to the TX FIFO
//   o_tx_wr       TX push strobe
//   o_rwaddr      register address to uart_regs
//   o_write_data  register write data to uart_regs
//   o_rd_req      register read strobe
//   o_wr_req      register write strobe
//   i_read_data   register read data, valid the cycle after o_rd_req
//   o_busy        high whenever the FSM is not idle
//   o_cmd_err     one-cycle pulse on a malformed command or data timeout
// ---------------------------------------------------------------------------
module uart_cmd_master #(
    parameter int unsigned TIMEOUT_CYCLES = 50000,
    parameter logic [7:0]  ACK_BYTE       = 8'hA5
) (
    input  logic       i_clk,
    input  logic       i_rst_n,
    input  logic       i_rx_fifo_e,
    input  logic [7:0] i_rx_data,
    output logic       o_rx_rd,
    input  logic       i_tx_fifo_f,
    output logic [7:0] o_tx_data,
    output logic       o_tx_wr,
    output logic [2:0] o_rwaddr,
    output logic [7:0] o_write_data,
    output logic       o_rd_req,
    output logic       o_wr_req,
    input  logic [7:0] i_read_data,
    output logic       o_busy,
    output logic       o_cmd_err
);

    localparam int unsigned      CNT_W    = $clog2(TIMEOUT_CYCLES);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        GET_DATA = 3'd1,
        WR       = 3'd2,
        RD       = 3'd3,
        RD_CAP   = 3'd4,
        TX       = 3'd5
`ifdef UART_CMD_ACK_EN
        ,
        ACK      = 3'd6
`endif
    } state_t;

    state_t           state_q;
    state_t           state_d;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       rwaddr_q;
    logic [7:0]       wdata_q;
    logic [7:0]       tx_data_q;

    logic rx_avail;
    logic cmd_bad;
    logic timeout_hit;
    logic push_state;

    assign rx_avail    = !i_rx_fifo_e;
    assign cmd_bad     = |i_rx_data[6:3];
    assign timeout_hit = (cnt_q == CNT_LAST);

`ifdef UART_CMD_ACK_EN
    assign push_state  = (state_q == TX) || (state_q == ACK);
`else
    assign push_state  = (state_q == TX);
    // ACK_BYTE has no consumer when the ACK state is not built.
    logic unused_ack_byte;
    assign unused_ack_byte = ^ACK_BYTE;
`endif

    // ---- state register ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // ---- next-state logic ----
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (rx_avail && !cmd_bad) begin
                    state_d = i_rx_data[7] ? GET_DATA : RD;
                end
            end
            GET_DATA: begin
                // An arriving data byte wins over a simultaneous timeout.
                if (rx_avail) begin
                    state_d = WR;
                end else if (timeout_hit) begin
                    state_d = IDLE;
                end
            end
            WR: begin
`ifdef UART_CMD_ACK_EN
                state_d = ACK;
`else
                state_d = IDLE;
`endif
            end
            RD:     state_d = RD_CAP;
            RD_CAP: state_d = TX;
            TX: begin
                if (!i_tx_fifo_f) begin
                    state_d = IDLE;
                end
            end
`ifdef UART_CMD_ACK_EN
            ACK: begin
                if (!i_tx_fifo_f) begin
                    state_d = IDLE;
                end
            end
`endif
            default: state_d = IDLE;
        endcase
    end

    // ---- output decode ----
    // The input-dependent strobes are gated by reset so that every output
    // reads zero while reset is held, regardless of the FIFO flags.
    always_comb begin
        o_rx_rd   = 1'b0;
        o_cmd_err = 1'b0;
        o_rd_req  = 1'b0;
        o_wr_req  = 1'b0;
        o_tx_wr   = 1'b0;
        o_busy    = 1'b0;
        if (i_rst_n) begin
            o_rx_rd   = ((state_q == IDLE) || (state_q == GET_DATA)) && rx_avail;
            o_cmd_err = ((state_q == IDLE) && rx_avail && cmd_bad) ||
                        ((state_q == GET_DATA) && !rx_avail && timeout_hit);
        end
        o_rd_req = (state_q == RD);
        o_wr_req = (state_q == WR);
        o_tx_wr  = push_state && !i_tx_fifo_f;
        o_busy   = (state_q != IDLE);
    end

    // ---- command / data / timeout registers ----
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            cnt_q     <= '0;
            rwaddr_q  <= 3'd0;
            wdata_q   <= 8'd0;
            tx_data_q <= 8'd0;
        end else begin
            // Counts empty cycles spent in GET_DATA; any other state clears
            // it, so every entry into GET_DATA starts from zero.
            if ((state_q == GET_DATA) && !rx_avail) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end else begin
                cnt_q <= '0;
            end

            if ((state_q == IDLE) && rx_avail && !cmd_bad) begin
                rwaddr_q <= i_rx_data[2:0];
            end

            if ((state_q == GET_DATA) && rx_avail) begin
                wdata_q <= i_rx_data;
            end

            if (state_q == RD_CAP) begin
                tx_data_q <= i_read_data;
            end
`ifdef UART_CMD_ACK_EN
            // Load the acknowledge byte as the FSM enters ACK.
            if (state_q == WR) begin
                tx_data_q <= ACK_BYTE;
            end
`endif
        end
    end

    assign o_rwaddr     = rwaddr_q;
    assign o_write_data = wdata_q;
    assign o_tx_data    = tx_data_q;

endmodule
